mode_sequencer: RTL

- Parametrised successor to the three-state game/volume/level mode selector.
- Cycles through NUM_MODES UI modes using forward and backward keys, with internal rising-edge detection.
- Adds long-press return-home, idle timeout back to mode 0, and a lock input that freezes the mode during gameplay.
- Sits between the key/button synchroniser and the mode-dependent datapaths (game, volume, level).

---
 rtl/mode_sequencer.sv | 95 +++++++++
 1 files changed

// File: rtl/mode_sequencer.sv
// UI mode selector: steps through NUM_MODES modes on forward/backward key presses,
// with long-press return-home, idle timeout to mode 0 and a gameplay lock.
module mode_sequencer #(
  parameter int NUM_MODES   = 3,
  parameter int MODE_W      = 2,
  parameter int TIMEOUT_CYC = 1000,
  parameter int HOLD_CYC    = 500
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              next_i,
  input  logic              prev_i,
  input  logic              lock_i,
  output logic [MODE_W-1:0] mode,
  output logic              mode_changed,
  output logic              timeout_pulse
);

  localparam int IDLE_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);
  localparam logic [MODE_W-1:0] MODE_LAST = MODE_W'(NUM_MODES - 1);
  localparam logic [MODE_W:0]   MODE_LIM  = (MODE_W + 1)'(NUM_MODES);

  logic              next_q, prev_q;
  logic [IDLE_W-1:0] idle_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic              hold_fired;

  logic nxt_ev, prv_ev, illegal, hold_hit, to_hit;

  assign nxt_ev   = next_i & ~next_q;
  assign prv_ev   = prev_i & ~prev_q;
  assign illegal  = ({1'b0, mode} >= MODE_LIM);
  assign hold_hit = (HOLD_CYC != 0) && next_i && (hold_cnt == HOLD_LAST) && !hold_fired;
  assign to_hit   = (TIMEOUT_CYC != 0) && (mode != '0) && (idle_cnt == IDLE_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode          <= '0;
      mode_changed  <= 1'b0;
      timeout_pulse <= 1'b0;
      idle_cnt      <= '0;
      hold_cnt      <= '0;
      hold_fired    <= 1'b0;
      // keys held through reset release must not register as presses
      next_q        <= 1'b1;
      prev_q        <= 1'b1;
    end else begin
      next_q        <= next_i;
      prev_q        <= prev_i;
      mode_changed  <= 1'b0;
      timeout_pulse <= 1'b0;

      if (lock_i || !next_i) begin
        hold_cnt   <= '0;
        hold_fired <= 1'b0;
      end else begin
        if (hold_cnt != HOLD_LAST) hold_cnt <= hold_cnt + 1'b1;
        if (hold_hit) hold_fired <= 1'b1;
      end

      if (illegal) begin
        mode         <= '0;
        mode_changed <= 1'b1;
        idle_cnt     <= '0;
      end else if (lock_i) begin
        idle_cnt <= '0;
      end else if (hold_hit) begin
        mode         <= '0;
        mode_changed <= (mode != '0);
        idle_cnt     <= '0;
      end else if (to_hit) begin
        mode          <= '0;
        mode_changed  <= 1'b1;
        timeout_pulse <= 1'b1;
        idle_cnt      <= '0;
      end else if (nxt_ev && !prv_ev) begin
        mode         <= (mode == MODE_LAST) ? '0 : mode + 1'b1;
        mode_changed <= 1'b1;
        idle_cnt     <= '0;
      end else if (prv_ev && !nxt_ev) begin
        mode         <= (mode == '0) ? MODE_LAST : mode - 1'b1;
        mode_changed <= 1'b1;
        idle_cnt     <= '0;
      end else if (nxt_ev || prv_ev || (mode == '0) || (TIMEOUT_CYC == 0)) begin
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + 1'b1;
      end
    end
  end

endmodule
